// File: rtl/mem_sram_stage_pkg.sv
// Shared types and constants for the SRAM-backed memory stage.
package mem_sram_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } stage_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          SRAM_ADDR_W       = 18;
    localparam int          SRAM_DATA_W       = 16;
    localparam int          PHASE_CNT_W       = 4;

endpackage

// File: rtl/mem_sram_stage_phase_counter.sv
// Halfword phase timer: counts cycles spent in a phase and flags the last one.
module sram_phase_counter
    import mem_sram_stage_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + PHASE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == PHASE_CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_sram_stage.sv
// Memory stage front-end for a 16-bit SRAM: each 32-bit load/store runs as a
// low then high halfword phase while the pipeline is frozen.
//
// state | meaning
// IDLE  | no access in flight; a request starts one
// LOW   | SRAM word 2n (data bits 15:0) driven for WAIT_CYCLES cycles
// HIGH  | SRAM word 2n+1 (data bits 31:16) driven for WAIT_CYCLES cycles
// DONE  | access complete; stage may advance for one cycle
module mem_sram_stage
    import mem_sram_stage_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   WB_EN,
    input  logic                   MEM_Read,
    input  logic                   MEM_Write,
    input  logic [31:0]            ALU_result,
    input  logic [31:0]            val_src2,
    input  logic [4:0]             dest,
    input  logic [SRAM_DATA_W-1:0] sram_rdata,
    output logic                   WB_EN_out,
    output logic                   MEM_Read_out,
    output logic [31:0]            ALU_result_out,
    output logic [4:0]             dest_out,
    output logic [31:0]            mem_read_data,
    output logic                   ready,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_wdata,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    stage_state_e state_q, state_d;

    logic                   req;
    logic                   phase_tc;
    logic                   cnt_clear;
    logic                   cnt_en;
    logic                   start_acc;
    logic                   low_done;
    logic                   high_done;
    logic                   ready_d;
    logic [SRAM_ADDR_W-2:0] word_idx;
    logic [SRAM_ADDR_W-2:0] word_q;
    logic [SRAM_DATA_W-1:0] wdata_hi_q;
    logic                   is_write_q;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [SRAM_DATA_W-1:0] wdata_q;
    logic                   we_n_q;
    logic                   oe_n_q;
    logic [31:0]            rdata_q;

    assign req = MEM_Read | MEM_Write;

    // Only offset bits [18:2] select the SRAM word pair, so a 19-bit difference suffices.
    assign word_idx = (SRAM_ADDR_W-1)'((ALU_result[18:0] - BASE_ADDR[18:0]) >> 2);

    sram_phase_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_phase_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .tc_o    (phase_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        start_acc = 1'b0;
        low_done  = 1'b0;
        high_done = 1'b0;
        ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = ~req;
                if (req) begin
                    state_d   = LOW;
                    cnt_clear = 1'b1;
                    start_acc = 1'b1;
                end
            end
            LOW: begin
                cnt_en = 1'b1;
                if (phase_tc) begin
                    state_d   = HIGH;
                    cnt_clear = 1'b1;
                    low_done  = 1'b1;
                end
            end
            HIGH: begin
                cnt_en = 1'b1;
                if (phase_tc) begin
                    state_d   = DONE;
                    high_done = 1'b1;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM pins are registered so they change only on phase boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q     <= '0;
            wdata_hi_q <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            rdata_q    <= '0;
        end else begin
            if (start_acc) begin
                word_q     <= word_idx;
                wdata_hi_q <= val_src2[31:16];
                is_write_q <= MEM_Write;
                addr_q     <= {word_idx, 1'b0};
                we_n_q     <= ~MEM_Write;
                oe_n_q     <= MEM_Write;
                if (MEM_Write) begin
                    wdata_q <= val_src2[15:0];
                end
            end
            if (low_done) begin
                addr_q <= {word_q, 1'b1};
                if (is_write_q) begin
                    wdata_q <= wdata_hi_q;
                end else begin
                    rdata_q[15:0] <= sram_rdata;
                end
            end
            if (high_done) begin
                we_n_q <= 1'b1;
                oe_n_q <= 1'b1;
                if (!is_write_q) begin
                    rdata_q[31:16] <= sram_rdata;
                end
            end
        end
    end

    assign WB_EN_out      = WB_EN;
    assign MEM_Read_out   = MEM_Read;
    assign ALU_result_out = ALU_result;
    assign dest_out       = dest;
    assign mem_read_data  = rdata_q;
    assign ready          = ready_d;
    assign freeze         = ~ready_d;
    assign sram_addr      = addr_q;
    assign sram_wdata     = wdata_q;
    assign sram_we_n      = we_n_q;
    assign sram_oe_n      = oe_n_q;

endmodule

// File: tb/tb_mem_sram_stage.sv
// Directed bench for mem_sram_stage: one instance at WAIT_CYCLES=2 and one at
// WAIT_CYCLES=1, each with a small behavioural SRAM attached.
module tb_mem_sram_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic        WB_EN, MEM_Read, MEM_Write;
    logic [31:0] ALU_result, val_src2;
    logic [4:0]  dest;

    logic [15:0] rdata_a, wdata_a, rdata_b, wdata_b;
    logic        wb_a, mr_a, ready_a, freeze_a, we_n_a, oe_n_a;
    logic        wb_b, mr_b, ready_b, freeze_b, we_n_b, oe_n_b;
    logic [31:0] alu_a, mrd_a, alu_b, mrd_b;
    logic [4:0]  dest_a, dest_b;
    logic [17:0] addr_a, addr_b;

    logic [15:0] mem_a [64];
    logic [15:0] mem_b [64];

    int n_checks = 0;
    int n_fail   = 0;
    int fr_st, fr_ld;

    always #5 clk = ~clk;

    mem_sram_stage #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut_a (
        .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_Read(MEM_Read), .MEM_Write(MEM_Write),
        .ALU_result(ALU_result), .val_src2(val_src2), .dest(dest), .sram_rdata(rdata_a),
        .WB_EN_out(wb_a), .MEM_Read_out(mr_a), .ALU_result_out(alu_a), .dest_out(dest_a),
        .mem_read_data(mrd_a), .ready(ready_a), .freeze(freeze_a), .sram_addr(addr_a),
        .sram_wdata(wdata_a), .sram_we_n(we_n_a), .sram_oe_n(oe_n_a)
    );

    mem_sram_stage #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut_b (
        .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_Read(MEM_Read), .MEM_Write(MEM_Write),
        .ALU_result(ALU_result), .val_src2(val_src2), .dest(dest), .sram_rdata(rdata_b),
        .WB_EN_out(wb_b), .MEM_Read_out(mr_b), .ALU_result_out(alu_b), .dest_out(dest_b),
        .mem_read_data(mrd_b), .ready(ready_b), .freeze(freeze_b), .sram_addr(addr_b),
        .sram_wdata(wdata_b), .sram_we_n(we_n_b), .sram_oe_n(oe_n_b)
    );

    // Behavioural SRAMs: synchronous write on we_n low, asynchronous read gated by oe_n.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= 16'h0000;
                mem_b[i] <= 16'h0000;
            end
            mem_a[0] <= 16'h1234;
            mem_a[1] <= 16'h5678;
        end else begin
            if (!we_n_a) mem_a[addr_a[5:0]] <= wdata_a;
            if (!we_n_b) mem_b[addr_b[5:0]] <= wdata_b;
        end
    end

    assign rdata_a = oe_n_a ? 16'h0000 : mem_a[addr_a[5:0]];
    assign rdata_b = oe_n_b ? 16'h0000 : mem_b[addr_b[5:0]];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        WB_EN = 1'b0; MEM_Read = 1'b0; MEM_Write = 1'b0;
        ALU_result = '0; val_src2 = '0; dest = '0;
        #1;
        check_eq("rst_addr",  32'(addr_a),  32'd0);
        check_eq("rst_wdata", 32'(wdata_a), 32'd0);
        check_eq("rst_we_n",  32'(we_n_a),  32'd1);
        check_eq("rst_oe_n",  32'(oe_n_a),  32'd1);
        check_eq("rst_mrd",   mrd_a,        32'd0);
        check_eq("rst_ready", 32'(ready_a), 32'd1);
        cyc(); cyc();
        rst = 1'b0; mem_init = 1'b0;
        cyc();

        // store 0xDEADBEEF to byte 1028; inputs scrambled after launch
        MEM_Write = 1'b1; ALU_result = 32'd1028; val_src2 = 32'hDEADBEEF; #1;
        check_eq("st_c0_ready",  32'(ready_a),  32'd0);
        check_eq("st_c0_freeze", 32'(freeze_a), 32'd1);
        cyc();
        MEM_Write = 1'b0; ALU_result = 32'd0; val_src2 = 32'h0; #1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) cyc();
            check_eq($sformatf("st_addr_c%0d", c),  32'(addr_a),  (c <= 2) ? 32'd2 : 32'd3);
            check_eq($sformatf("st_wdata_c%0d", c), 32'(wdata_a), (c <= 2) ? 32'h0000BEEF : 32'h0000DEAD);
            check_eq($sformatf("st_we_n_c%0d", c),  32'(we_n_a),  (c <= 4) ? 32'd0 : 32'd1);
            check_eq($sformatf("st_oe_n_c%0d", c),  32'(oe_n_a),  32'd1);
            check_eq($sformatf("st_ready_c%0d", c), 32'(ready_a), (c == 5) ? 32'd1 : 32'd0);
        end

        // load from byte 1024, SRAM holds 1234 / 5678
        cyc();
        MEM_Read = 1'b1; ALU_result = 32'd1024; #1;
        check_eq("ld_c0_ready", 32'(ready_a), 32'd0);
        cyc();
        MEM_Read = 1'b0; ALU_result = 32'd0; #1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) cyc();
            check_eq($sformatf("ld_addr_c%0d", c),  32'(addr_a),  (c <= 2) ? 32'd0 : 32'd1);
            check_eq($sformatf("ld_oe_n_c%0d", c),  32'(oe_n_a),  (c <= 4) ? 32'd0 : 32'd1);
            check_eq($sformatf("ld_we_n_c%0d", c),  32'(we_n_a),  32'd1);
            check_eq($sformatf("ld_ready_c%0d", c), 32'(ready_a), (c == 5) ? 32'd1 : 32'd0);
            if (c == 3) check_eq("ld_lo_half", 32'(mrd_a[15:0]), 32'h00001234);
        end
        check_eq("ld_word", mrd_a, 32'h56781234);

        // no request: pass-through only
        cyc();
        WB_EN = 1'b1; ALU_result = 32'd7; dest = 5'd3; #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            check_eq("nr_ready_a",  32'(ready_a),  32'd1);
            check_eq("nr_freeze_a", 32'(freeze_a), 32'd0);
            check_eq("nr_alu_a",    alu_a,         32'd7);
            check_eq("nr_dest_a",   32'(dest_a),   32'd3);
            check_eq("nr_wb_a",     32'(wb_a),     32'd1);
            check_eq("nr_mr_a",     32'(mr_a),     32'd0);
            check_eq("nr_we_n_a",   32'(we_n_a),   32'd1);
            check_eq("nr_oe_n_a",   32'(oe_n_a),   32'd1);
            check_eq("nr_ready_b",  32'(ready_b),  32'd1);
            check_eq("nr_alu_b",    alu_b,         32'd7);
            check_eq("nr_dest_b",   32'(dest_b),   32'd3);
            check_eq("nr_wb_b",     32'(wb_b),     32'd1);
        end
        check_eq("nr_wdata_hold", 32'(wdata_a), 32'h0000DEAD);
        check_eq("nr_mrd_hold",   mrd_a,        32'h56781234);

        // read and write together at byte 1032 -> write wins
        cyc();
        MEM_Read = 1'b1; MEM_Write = 1'b1; ALU_result = 32'd1032;
        val_src2 = 32'hA5A50F0F; WB_EN = 1'b0; dest = 5'd9; #1;
        check_eq("rw_mr_out",   32'(mr_a),    32'd1);
        check_eq("rw_dest_out", 32'(dest_a),  32'd9);
        check_eq("rw_wb_out",   32'(wb_a),    32'd0);
        check_eq("rw_c0_ready", 32'(ready_a), 32'd0);
        cyc();
        MEM_Read = 1'b0; MEM_Write = 1'b0; val_src2 = 32'h0; #1;
        check_eq("rw_we_n", 32'(we_n_a), 32'd0);
        check_eq("rw_oe_n", 32'(oe_n_a), 32'd1);
        check_eq("rw_addr", 32'(addr_a), 32'd4);
        cyc(); cyc(); cyc(); cyc();
        check_eq("rw_ready",  32'(ready_a),  32'd1);
        check_eq("rw_mem_lo", 32'(mem_a[4]), 32'h00000F0F);
        check_eq("rw_mem_hi", 32'(mem_a[5]), 32'h0000A5A5);
        check_eq("rw_mrd",    mrd_a,         32'h56781234);

        // reset pulsed during HIGH of a store to byte 1036
        cyc();
        MEM_Write = 1'b1; ALU_result = 32'd1036; val_src2 = 32'h11112222; #1;
        cyc();
        MEM_Write = 1'b0; val_src2 = 32'h0;
        cyc(); cyc();
        check_eq("ab_high_addr", 32'(addr_a),  32'd7);
        check_eq("ab_high_we_n", 32'(we_n_a),  32'd0);
        check_eq("ab_high_wd",   32'(wdata_a), 32'h00001111);
        #1 rst = 1'b1;
        #1;
        check_eq("ab_rst_we_n",  32'(we_n_a),  32'd1);
        check_eq("ab_rst_oe_n",  32'(oe_n_a),  32'd1);
        check_eq("ab_rst_addr",  32'(addr_a),  32'd0);
        check_eq("ab_rst_wdata", 32'(wdata_a), 32'd0);
        check_eq("ab_rst_mrd",   mrd_a,        32'd0);
        check_eq("ab_rst_ready", 32'(ready_a), 32'd1);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("ab_post_we_n",  32'(we_n_a),  32'd1);
            check_eq("ab_post_oe_n",  32'(oe_n_a),  32'd1);
            check_eq("ab_post_addr",  32'(addr_a),  32'd0);
            check_eq("ab_post_ready", 32'(ready_a), 32'd1);
        end
        check_eq("ab_mem_lo", 32'(mem_a[6]), 32'h00002222);
        check_eq("ab_mem_hi", 32'(mem_a[7]), 32'h00000000);

        // back-to-back store then load at byte 1040 on the WAIT_CYCLES=1 instance
        cyc();
        MEM_Write = 1'b1; ALU_result = 32'd1040; val_src2 = 32'hCAFEF00D; #1;
        fr_st = 0; fr_ld = 0;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) cyc();
            if (c == 1) begin
                MEM_Write = 1'b0; MEM_Read = 1'b1; val_src2 = 32'h0; #1;
            end
            check_eq($sformatf("bb_ready_c%0d", c), 32'(ready_b), (c == 3 || c == 7) ? 32'd1 : 32'd0);
            if (c < 4) fr_st += int'(freeze_b);
            else       fr_ld += int'(freeze_b);
            if (c == 5) check_eq("bb_ld_addr_lo", 32'(addr_b), 32'd8);
            if (c == 6) check_eq("bb_ld_addr_hi", 32'(addr_b), 32'd9);
            if (c == 7) begin
                check_eq("bb_mrd", mrd_b, 32'hCAFEF00D);
                MEM_Read = 1'b0;
            end
        end
        check_eq("bb_store_freeze", 32'(fr_st), 32'd3);
        check_eq("bb_load_freeze",  32'(fr_ld), 32'd3);

        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
